// File: rtl/stable_match_sched.sv
// stable_match_sched: round-robin scheduler issuing one eligible free man per proposal, with convergence and runaway detection
module stable_match_sched #(
    parameter int M       = 8,
    parameter int Km      = 8,
    parameter int TIMEOUT = 255,
    localparam int LOGM   = $clog2(M),
    localparam int CW     = $clog2(M * Km + 1),
    localparam int TW     = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [M-1:0]    m_free,
    input  logic [M-1:0]    m_exhausted,
    output logic            prop_valid,
    output logic [LOGM-1:0] prop_m,
    input  logic            prop_ready,
    input  logic            prop_done,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [CW-1:0]   prop_cnt
);
    typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, SETTLE, DONE, ERROR} state_t;

    state_t          r_state;
    logic [LOGM-1:0] r_ptr;
    logic [LOGM-1:0] r_prop_m;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_wait;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [M-1:0]    w_elig;
    logic [LOGM-1:0] w_pick;

    function automatic logic [LOGM-1:0] wrap_add(input logic [LOGM-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        return LOGM'(s >= M ? s - M : s);
    endfunction

    assign w_elig = m_free & ~m_exhausted;

    // descending offsets so the candidate nearest the pointer is written last and wins
    always_comb begin
        w_pick = '0;
        for (int k = M - 1; k >= 0; k--)
            w_pick = w_elig[wrap_add(r_ptr, k)] ? wrap_add(r_ptr, k) : w_pick;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_prop_m <= '0;
            r_cnt    <= '0;
            r_wait   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: if (start) begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= SCAN;
                end
                SCAN: if (w_elig == '0) begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DONE;
                end else begin
                    r_prop_m <= w_pick;
                    r_valid  <= 1'b1;
                    r_state  <= ISSUE;
                end
                ISSUE: if (prop_ready) begin
                    r_valid <= 1'b0;
                    if (r_cnt == CW'(M * Km)) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ERROR;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_ptr   <= wrap_add(r_prop_m, 1);
                        r_wait  <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: if (prop_done) begin
                    r_state <= SETTLE;
                end else if (r_wait == TW'(TIMEOUT)) begin
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ERROR;
                end else begin
                    r_wait <= r_wait + 1'b1;
                end
                SETTLE: r_state <= SCAN;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign prop_valid = r_valid;
    assign prop_m     = r_prop_m;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign prop_cnt   = r_cnt;
endmodule

// File: tb/tb_stable_match_sched.sv
// tb_stable_match_sched: randomized self-checking bench against a pointer/counter reference model
module tb_stable_match_sched;
    logic       clk = 1'b0;
    logic       rst, start, prop_ready, prop_done;
    logic [7:0] m_free, m_exhausted;
    logic       prop_valid, busy, done, err;
    logic [2:0] prop_m;
    logic [6:0] prop_cnt;
    int n_chk = 0;
    int n_fail = 0;
    int exp_ptr = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    stable_match_sched dut (
        .clk(clk), .rst(rst), .start(start), .m_free(m_free), .m_exhausted(m_exhausted),
        .prop_valid(prop_valid), .prop_m(prop_m), .prop_ready(prop_ready), .prop_done(prop_done),
        .busy(busy), .done(done), .err(err), .prop_cnt(prop_cnt)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input int p, input logic [7:0] e);
        for (int k = 0; k < 8; k++)
            if (e[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic start_run;
        start = 1'b1;
        step;
        start = 1'b0;
        exp_cnt = 0;
        n_chk++;
        if ({busy, done, err, prop_valid, prop_cnt} !== {4'b1000, 7'd0}) begin
            n_fail++;
            $display("FAIL start: busy/done/err/valid/cnt=%b%b%b%b/%0d expected 1000/0", busy, done, err, prop_valid, prop_cnt);
        end
    endtask

    // one proposal round entered from SCAN; leaves the DUT in the next SCAN (or DONE/ERROR)
    task automatic do_round(input logic [7:0] fr, input logic [7:0] ex, input int dly);
        logic [7:0] e;
        int g;
        m_free = fr;
        m_exhausted = ex;
        e = fr & ~ex;
        step;
        if (e == 8'd0) begin
            n_chk++;
            if ({done, busy, prop_valid, err} !== 4'b1000 || prop_cnt !== 7'(exp_cnt)) begin
                n_fail++;
                $display("FAIL converge: done/busy/valid/err=%b%b%b%b cnt=%0d expected 1000 cnt=%0d", done, busy, prop_valid, err, prop_cnt, exp_cnt);
            end
            return;
        end
        g = pick(exp_ptr, e);
        n_chk++;
        if (prop_valid !== 1'b1 || prop_m !== 3'(g)) begin
            n_fail++;
            $display("FAIL grant: valid=%b m=%0d expected valid=1 m=%0d", prop_valid, prop_m, g);
        end
        prop_ready = 1'b0;
        for (int i = 0; i < dly; i++) begin
            step;
            n_chk++;
            if (prop_valid !== 1'b1 || prop_m !== 3'(g) || prop_cnt !== 7'(exp_cnt)) begin
                n_fail++;
                $display("FAIL stall: valid=%b m=%0d cnt=%0d expected 1 %0d %0d", prop_valid, prop_m, prop_cnt, g, exp_cnt);
            end
        end
        prop_ready = 1'b1;
        step;
        prop_ready = 1'b0;
        if (exp_cnt == 64) begin
            n_chk++;
            if ({err, busy, prop_valid} !== 3'b100 || prop_cnt !== 7'd64) begin
                n_fail++;
                $display("FAIL bound: err/busy/valid=%b%b%b cnt=%0d expected 100 cnt=64", err, busy, prop_valid, prop_cnt);
            end
            return;
        end
        exp_cnt++;
        exp_ptr = (g + 1) % 8;
        n_chk++;
        if ({prop_valid, busy} !== 2'b01 || prop_cnt !== 7'(exp_cnt)) begin
            n_fail++;
            $display("FAIL transfer: valid/busy=%b%b cnt=%0d expected 01 cnt=%0d", prop_valid, busy, prop_cnt, exp_cnt);
        end
        prop_done = 1'b1;
        step;
        prop_done = 1'b0;
        step;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; prop_ready = 1'b0; prop_done = 1'b0;
        m_free = 8'd0; m_exhausted = 8'd0;
        step;
        step;
        n_chk++;
        if ({prop_valid, prop_m, busy, done, err, prop_cnt} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b m=%0d busy=%b done=%b err=%b cnt=%0d expected all 0", prop_valid, prop_m, busy, done, err, prop_cnt);
        end
        rst = 1'b1;
        exp_ptr = 0;
        exp_cnt = 0;
        step;
        n_chk++;
        if ({prop_valid, busy, done, err} !== 4'd0) begin
            n_fail++;
            $display("FAIL idle: valid/busy/done/err=%b%b%b%b expected 0000", prop_valid, busy, done, err);
        end
    endtask

    task automatic test_sweep;
        start_run;
        for (int i = 0; i < 8; i++) do_round(8'hFF, 8'h00, 0);
        n_chk++;
        if (prop_cnt !== 7'd8 || exp_ptr != 0) begin
            n_fail++;
            $display("FAIL sweep_cnt: cnt=%0d expected 8", prop_cnt);
        end
        do_round(8'h00, 8'h00, 0);
    endtask

    task automatic test_wrap;
        start_run;
        do_round(8'h01, 8'h00, 0);
        do_round(8'h00, 8'h00, 0);
        start_run;
        do_round(8'h81, 8'h00, 0);
        do_round(8'h81, 8'h00, 0);
        n_chk++;
        if (prop_cnt !== 7'd2) begin
            n_fail++;
            $display("FAIL wrap_cnt: cnt=%0d expected 2", prop_cnt);
        end
        do_round(8'h40, 8'h00, 0);
        do_round(8'h01, 8'h00, 0);
        do_round(8'h00, 8'h00, 0);
    endtask

    task automatic test_ready_stall;
        start_run;
        do_round(8'hFF, 8'h00, 5);
        do_round(8'h3C, 8'h0C, 5);
        do_round(8'hFF, 8'hFF, 0);
    endtask

    task automatic test_empty;
        start_run;
        do_round(8'h00, 8'h00, 0);
    endtask

    task automatic test_timeout;
        int g;
        start_run;
        m_free = 8'hFF;
        m_exhausted = 8'h00;
        step;
        g = pick(exp_ptr, 8'hFF);
        prop_ready = 1'b1;
        step;
        prop_ready = 1'b0;
        exp_cnt++;
        exp_ptr = (g + 1) % 8;
        for (int i = 0; i < 255; i++) begin
            step;
            n_chk++;
            if ({err, busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL wait_%0d: err/busy=%b%b expected 01", i, err, busy);
            end
        end
        step;
        n_chk++;
        if ({err, busy, done} !== 3'b100 || prop_cnt !== 7'(exp_cnt)) begin
            n_fail++;
            $display("FAIL timeout: err/busy/done=%b%b%b cnt=%0d expected 100 cnt=%0d", err, busy, done, prop_cnt, exp_cnt);
        end
        start_run;
        do_round(8'hFF, 8'h00, 0);
        do_round(8'h00, 8'h00, 0);
    endtask

    task automatic test_reset_mid;
        start_run;
        m_free = 8'hFF;
        step;
        prop_ready = 1'b1;
        step;
        prop_ready = 1'b0;
        rst = 1'b0;
        step;
        rst = 1'b1;
        exp_ptr = 0;
        exp_cnt = 0;
        n_chk++;
        if ({prop_valid, prop_m, busy, done, err, prop_cnt} !== 14'd0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b m=%0d busy=%b done=%b err=%b cnt=%0d expected all 0", prop_valid, prop_m, busy, done, err, prop_cnt);
        end
        prop_done = 1'b1;
        step;
        prop_done = 1'b0;
        step;
        n_chk++;
        if ({prop_valid, busy, done, err} !== 4'd0) begin
            n_fail++;
            $display("FAIL stray_done: valid/busy/done/err=%b%b%b%b expected 0000", prop_valid, busy, done, err);
        end
        start_run;
        do_round(8'hFF, 8'h00, 0);
        do_round(8'h00, 8'h00, 0);
    endtask

    task automatic test_bound;
        start_run;
        for (int i = 0; i < 65; i++) do_round(8'hFF, 8'h00, 0);
        start_run;
        do_round(8'h00, 8'h00, 0);
    endtask

    task automatic test_random;
        logic [7:0] fr, ex;
        bit ended;
        for (int r = 0; r < 20; r++) begin
            start_run;
            ended = 1'b0;
            for (int j = 0; j < 12 && !ended; j++) begin
                fr = 8'($urandom);
                ex = 8'($urandom);
                if ($urandom_range(0, 7) == 0) fr = 8'h00;
                do_round(fr, ex, int'($urandom_range(0, 3)));
                ended = ((fr & ~ex) == 8'd0);
            end
            if (!ended) do_round(8'h00, 8'h00, 0);
        end
    endtask

    initial begin
        test_reset;
        test_sweep;
        test_wrap;
        test_ready_stall;
        test_empty;
        test_timeout;
        test_reset_mid;
        test_bound;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
